fetch_control_unit: RTL and testbench
=====================================

Name: fetch_control_unit

Overview:
- Instruction sequencer that drives the program counter's control interface: pc_enable, pc_load and pc_in.
- Receives the instruction word that instruction memory returns at the current PC address, holds it in an instruction register (IR) and runs a fixed FETCH/DECODE/EXECUTE cycle.
- Issues accumulator/ALU strobes and decides per instruction whether the PC increments, loads a branch target, or holds.
- Sits between instruction memory, the program counter and the datapath of the processor.

Parameters:
- WIDTH, 4, data, address and operand width; instruction word is 4+WIDTH bits (opcode[WIDTH+3:WIDTH], operand[WIDTH-1:0]).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level/pulse; leaves IDLE.
- instr_in  input  WIDTH+4  instruction word at current PC address, valid combinationally during FETCH.
- zero_flag  input  1  accumulator zero flag from datapath.
- carry_flag  input  1  ALU carry flag from datapath.
- pc_enable  output  1  one-cycle increment strobe to the PC.
- pc_load  output  1  one-cycle load strobe to the PC.
- pc_in  output  WIDTH  branch target; equals IR operand.
- ir_out  output  WIDTH+4  current IR contents.
- imm_out  output  WIDTH  IR operand to the datapath.
- alu_op  output  3  ALU function select.
- acc_load  output  1  one-cycle accumulator write strobe.
- busy  output  1  high in FETCH, DECODE and EXECUTE.
- halted  output  1  high in IDLE.
- illegal  output  1  sticky flag: an undefined opcode was executed.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE. Binary encoding.
- Reset: state=IDLE, IR=0, illegal=0. All strobes 0, pc_in=0, busy=0, halted=1. Reset in any state aborts the instruction with no strobe in that cycle.
- Only state, IR and illegal are registered. All other outputs decode combinationally from state and IR.
- IDLE: if start=1, go to FETCH next cycle; otherwise stay.
- FETCH: IR<=instr_in at the end of the cycle; go to DECODE.
- DECODE: no strobes; go to EXECUTE.
- EXECUTE: exactly one of pc_enable or pc_load is high, except HLT, where both are 0. Go to FETCH, or to IDLE for HLT. The PC updates on the edge that ends EXECUTE, so the next FETCH sees the new address.
- An instruction takes 3 cycles. pc_enable and pc_load are never both high.
- Opcodes:
  - 0 NOP: pc_enable.
  - 1 LDI: alu_op=000 (pass imm), acc_load, pc_enable.
  - 2 ADD: alu_op=001, acc_load, pc_enable.
  - 3 SUB: alu_op=010, acc_load, pc_enable.
  - 4 AND: alu_op=011, acc_load, pc_enable.
  - 5 OR: alu_op=100, acc_load, pc_enable.
  - 6 XOR: alu_op=101, acc_load, pc_enable.
  - 7 JMP: pc_load.
  - 8 JZ: pc_load if zero_flag, else pc_enable.
  - 9 JC: pc_load if carry_flag, else pc_enable.
  - F HLT: no PC strobe; go to IDLE.
  - A–E: treated as NOP (pc_enable); illegal<=1 at the end of EXECUTE.
- Flags are sampled combinationally during EXECUTE, not during DECODE.
- acc_load is high only in EXECUTE. alu_op=000 outside EXECUTE.
- pc_in = IR operand in every state; it only takes effect when pc_load=1.
- start is ignored outside IDLE.
- After HLT, a new start resumes at PC+0, i.e. HLT is re-fetched. Software restarts only through reset or a preceding jump.
- illegal is cleared only by reset.
- PC wrap-around from all-ones to 0 is the PC's concern; this block needs no special case.

Decomposition:
- Shared package fcu_pkg:
  - opcode constants OP_NOP..OP_HLT;
  - ALU select constants ALU_PASS..ALU_XOR;
  - state encoding constants.
- One combinational sub-module, instr_decoder: opcode, zero_flag and carry_flag in; alu_op, acc_load_req, pc_inc_req, pc_load_req, halt_req and illegal_req out. The top-level gates these requests with state==EXECUTE.

Test Plan:
- Reset, then start=1 for one cycle, with instr_in=0x1_5 (LDI 5) -> FETCH, DECODE, EXECUTE on cycles 1–3. In EXECUTE: acc_load=1, alu_op=000, imm_out=5, pc_enable=1, pc_load=0. Then back to FETCH.
- instr_in=0x7_A (JMP 10) -> in EXECUTE: pc_load=1, pc_in=10, pc_enable=0. No acc_load.
- JZ 3 with zero_flag=0 -> pc_enable=1 only. JZ 3 with zero_flag=1 -> pc_load=1, pc_in=3. Repeat with JC 3 and carry_flag.
- instr_in=0xF_0 (HLT) -> no PC strobe in EXECUTE; next state IDLE, halted=1, busy=0. start toggling during FETCH/DECODE/EXECUTE of earlier instructions causes no effect.
- instr_in=0xB_0 -> pc_enable=1 and illegal=1 after EXECUTE. illegal stays 1 through subsequent NOPs until reset.
- Assert reset in the DECODE cycle of an ADD -> no acc_load and no pc_enable ever issued. Next cycle: state IDLE, ir_out=0, halted=1.

Source files
------------

// File: rtl/fetch_control_unit_pkg.sv
// Shared constants for the fetch control unit: opcodes, ALU selects and
// the sequencer state encoding.
package fcu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } state_t;

endpackage

// File: rtl/fetch_control_unit_if.sv
// Bundle of all non-clock/reset signals between the fetch control unit
// and its surroundings (instruction memory, PC and datapath).
interface fetch_control_unit_if #(parameter int WIDTH = 4);

  logic             start;
  logic [WIDTH+3:0] instr_in;
  logic             zero_flag;
  logic             carry_flag;
  logic             pc_enable;
  logic             pc_load;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH+3:0] ir_out;
  logic [WIDTH-1:0] imm_out;
  logic [2:0]       alu_op;
  logic             acc_load;
  logic             busy;
  logic             halted;
  logic             illegal;

  modport master (
    input  start, instr_in, zero_flag, carry_flag,
    output pc_enable, pc_load, pc_in, ir_out, imm_out, alu_op,
           acc_load, busy, halted, illegal
  );

  modport slave (
    output start, instr_in, zero_flag, carry_flag,
    input  pc_enable, pc_load, pc_in, ir_out, imm_out, alu_op,
           acc_load, busy, halted, illegal
  );

endinterface

// File: rtl/fetch_control_unit_decoder.sv
// Purely combinational opcode decoder; produces requests that the
// sequencer only honours during EXECUTE.
module instr_decoder
  import fcu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic [2:0] alu_op,
  output logic       acc_load_req,
  output logic       pc_inc_req,
  output logic       pc_load_req,
  output logic       halt_req,
  output logic       illegal_req
);

  always_comb begin
    alu_op       = ALU_PASS;
    acc_load_req = 1'b0;
    pc_inc_req   = 1'b0;
    pc_load_req  = 1'b0;
    halt_req     = 1'b0;
    illegal_req  = 1'b0;
    case (opcode)
      OP_NOP: pc_inc_req = 1'b1;
      OP_LDI: begin alu_op = ALU_PASS; acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_ADD: begin alu_op = ALU_ADD;  acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB;  acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_AND: begin alu_op = ALU_AND;  acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;   acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR;  acc_load_req = 1'b1; pc_inc_req = 1'b1; end
      OP_JMP: pc_load_req = 1'b1;
      OP_JZ: begin
        pc_load_req = zero_flag;
        pc_inc_req  = ~zero_flag;
      end
      OP_JC: begin
        pc_load_req = carry_flag;
        pc_inc_req  = ~carry_flag;
      end
      OP_HLT: halt_req = 1'b1;
      // Opcodes A-E behave as NOP but are flagged as illegal
      default: begin
        pc_inc_req  = 1'b1;
        illegal_req = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Instruction sequencer: IDLE/FETCH/DECODE/EXECUTE cycle driving PC,
// accumulator and ALU strobes from the instruction register.
module fetch_control_unit
  import fcu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  fetch_control_unit_if.master bus
);

  state_t           state_q, state_d;
  logic [WIDTH+3:0] ir_q;
  logic             illegal_q;

  logic [3:0]       opcode;
  logic [2:0]       dec_alu_op;
  logic             acc_load_req, pc_inc_req, pc_load_req, halt_req, illegal_req;
  logic             in_execute;

  assign opcode = ir_q[WIDTH+3:WIDTH];

  instr_decoder u_decoder (
    .opcode       (opcode),
    .zero_flag    (bus.zero_flag),
    .carry_flag   (bus.carry_flag),
    .alu_op       (dec_alu_op),
    .acc_load_req (acc_load_req),
    .pc_inc_req   (pc_inc_req),
    .pc_load_req  (pc_load_req),
    .halt_req     (halt_req),
    .illegal_req  (illegal_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH)
        ir_q <= bus.instr_in;
      if (state_q == ST_EXECUTE && illegal_req)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = halt_req ? ST_IDLE : ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reset suppresses strobes in the cycle it is applied so an aborted
  // instruction never touches the PC or accumulator.
  assign in_execute = (state_q == ST_EXECUTE) && !reset;

  assign bus.pc_enable = in_execute && pc_inc_req;
  assign bus.pc_load   = in_execute && pc_load_req;
  assign bus.acc_load  = in_execute && acc_load_req;
  assign bus.alu_op    = in_execute ? dec_alu_op : ALU_PASS;
  assign bus.pc_in     = ir_q[WIDTH-1:0];
  assign bus.imm_out   = ir_q[WIDTH-1:0];
  assign bus.ir_out    = ir_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.halted    = (state_q == ST_IDLE);
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Randomized self-checking bench: a small program memory and PC model
// feed the sequencer, and every cycle is compared to the instruction rules.
module tb_fetch_control_unit;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;

  fetch_control_unit_if #(.WIDTH(WIDTH)) bus ();

  fetch_control_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         errorCount = 0;
  int         checkCount = 0;
  logic [7:0] mem [16];
  int         pc;
  bit         illegalModel;
  bit         idleModel;
  logic [7:0] lastIr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkQuiet(input string phase);
    checkOutput({phase, "_pc_enable"}, 32'(bus.pc_enable), 32'd0);
    checkOutput({phase, "_pc_load"},   32'(bus.pc_load),   32'd0);
    checkOutput({phase, "_acc_load"},  32'(bus.acc_load),  32'd0);
    checkOutput({phase, "_alu_op"},    32'(bus.alu_op),    32'd0);
  endtask

  // Reset during any phase: no strobes that cycle, then a clean IDLE.
  task automatic abortWithReset(input string phase);
    reset = 1'b1;
    #1;
    checkQuiet({phase, "_abort"});
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    #1;
    checkOutput("abort_halted",  32'(bus.halted),  32'd1);
    checkOutput("abort_busy",    32'(bus.busy),    32'd0);
    checkOutput("abort_ir_out",  32'(bus.ir_out),  32'd0);
    checkOutput("abort_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("abort_pc_in",   32'(bus.pc_in),   32'd0);
    pc           = 0;
    illegalModel = 1'b0;
    lastIr       = 8'h00;
    idleModel    = 1'b1;
  endtask

  task automatic startRun();
    bus.start    = 1'b1;
    bus.instr_in = 8'($urandom_range(0, 255));
    #1;
    checkOutput("idle_halted", 32'(bus.halted), 32'd1);
    checkOutput("idle_busy",   32'(bus.busy),   32'd0);
    checkQuiet("idle");
    @(negedge clk);
    idleModel = 1'b0;
  endtask

  // One full instruction starting in FETCH; zSel/cSel < 0 means random flag.
  task automatic applyStimulus(input int abortPhase, input int zSel, input int cSel);
    logic [7:0] instr;
    logic [3:0] op;
    logic [3:0] operand;
    bit         z, c, taken, halt, accExp;
    logic [2:0] aluExp;

    instr          = mem[pc];
    bus.instr_in   = instr;
    bus.start      = 1'($urandom_range(0, 1));
    bus.zero_flag  = 1'($urandom_range(0, 1));
    bus.carry_flag = 1'($urandom_range(0, 1));
    if (abortPhase == 1) begin abortWithReset("fetch"); return; end
    #1;
    checkOutput("fetch_busy",  32'(bus.busy),  32'd1);
    checkOutput("fetch_pc_in", 32'(bus.pc_in), 32'(lastIr[3:0]));
    checkQuiet("fetch");

    @(negedge clk);
    bus.instr_in   = 8'($urandom_range(0, 255));
    bus.start      = 1'($urandom_range(0, 1));
    bus.zero_flag  = 1'($urandom_range(0, 1));
    bus.carry_flag = 1'($urandom_range(0, 1));
    if (abortPhase == 2) begin abortWithReset("decode"); return; end
    #1;
    checkOutput("decode_ir_out",  32'(bus.ir_out),  32'(instr));
    checkOutput("decode_imm_out", 32'(bus.imm_out), 32'(instr[3:0]));
    checkQuiet("decode");
    lastIr = instr;

    @(negedge clk);
    z = (zSel < 0) ? 1'($urandom_range(0, 1)) : 1'(zSel);
    c = (cSel < 0) ? 1'($urandom_range(0, 1)) : 1'(cSel);
    bus.zero_flag  = z;
    bus.carry_flag = c;
    bus.start      = 1'($urandom_range(0, 1));
    if (abortPhase == 3) begin abortWithReset("execute"); return; end
    #1;
    op      = instr[7:4];
    operand = instr[3:0];
    taken   = (op == 4'd7) || (op == 4'd8 && z) || (op == 4'd9 && c);
    halt    = (op == 4'd15);
    accExp  = (op >= 4'd1 && op <= 4'd6);
    aluExp  = accExp ? 3'(op - 4'd1) : 3'd0;
    checkOutput("exec_pc_enable", 32'(bus.pc_enable), 32'(!taken && !halt));
    checkOutput("exec_pc_load",   32'(bus.pc_load),   32'(taken));
    checkOutput("exec_pc_in",     32'(bus.pc_in),     32'(operand));
    checkOutput("exec_imm_out",   32'(bus.imm_out),   32'(operand));
    checkOutput("exec_acc_load",  32'(bus.acc_load),  32'(accExp));
    checkOutput("exec_alu_op",    32'(bus.alu_op),    32'(aluExp));
    checkOutput("exec_busy",      32'(bus.busy),      32'd1);
    checkOutput("exec_illegal",   32'(bus.illegal),   32'(illegalModel));

    if (op >= 4'd10 && op <= 4'd14) illegalModel = 1'b1;
    if (taken)      pc = int'(operand);
    else if (!halt) pc = (pc + 1) % 16;
    idleModel = halt;

    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checkOutput("after_halted",  32'(bus.halted),  32'(halt));
    checkOutput("after_busy",    32'(bus.busy),    32'(!halt));
    checkOutput("after_illegal", 32'(bus.illegal), 32'(illegalModel));
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.instr_in   = '0;
    bus.zero_flag  = 1'b0;
    bus.carry_flag = 1'b0;
    pc             = 0;
    illegalModel   = 1'b0;
    idleModel      = 1'b1;
    lastIr         = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_halted",  32'(bus.halted),  32'd1);
    checkOutput("reset_busy",    32'(bus.busy),    32'd0);
    checkOutput("reset_ir_out",  32'(bus.ir_out),  32'd0);
    checkOutput("reset_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("reset_pc_in",   32'(bus.pc_in),   32'd0);
    checkQuiet("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed program: LDI, JMP, JZ/JC both ways, illegal, NOP, HLT
    mem[0]  = 8'h15;
    mem[1]  = 8'h7A;
    mem[10] = 8'h83;
    mem[11] = 8'h83;
    mem[3]  = 8'h95;
    mem[4]  = 8'h96;
    mem[6]  = 8'hB0;
    mem[7]  = 8'h00;
    mem[8]  = 8'hF0;
    startRun();
    applyStimulus(0, -1, -1);
    applyStimulus(0, -1, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 1, -1);
    applyStimulus(0, -1, 0);
    applyStimulus(0, -1, 1);
    applyStimulus(0, -1, -1);
    applyStimulus(0, -1, -1);
    applyStimulus(0, -1, -1);
    checkOutput("halt_pc_model", 32'(pc), 32'd8);

    // Restart after HLT re-fetches the same HLT
    startRun();
    applyStimulus(0, -1, -1);

    // Reset in the DECODE cycle of an ADD
    mem[8] = 8'h21;
    startRun();
    applyStimulus(2, -1, -1);

    // Randomized program runs with occasional aborts
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 250; n++) begin
      if (idleModel) begin
        if (mem[pc][7:4] == 4'hF && $urandom_range(0, 1) == 1)
          mem[pc] = 8'($urandom_range(0, 8'hEF));
        startRun();
      end
      applyStimulus(($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
